// File: rtl/display_counter.sv
// Multi-digit BCD/hex up/down counter with prescaler, load and seven-segment decode.
// Latency: Count/Tick/Wrap registered one cycle after the step or load edge; HEX combinational from Count.
// Backpressure: none; En freezes both the prescaler and the count.
module display_counter #(
    parameter int DIGITS   = 6,
    parameter int DECIMAL  = 1,
    parameter int TICK_DIV = 50000000,
    parameter int BLANK_LZ = 0
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic                  En,
    input  logic                  Up,
    input  logic                  Load,
    input  logic [4*DIGITS-1:0]   LoadVal,
    output logic [4*DIGITS-1:0]   Count,
    output logic [7*DIGITS-1:0]   HEX,
    output logic                  Tick,
    output logic                  Wrap
);

    localparam int             PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PTERM = PW'(TICK_DIV - 1);
    localparam logic [3:0]     DMAX  = (DECIMAL != 0) ? 4'd9 : 4'd15;

    logic [PW-1:0]       pcnt;
    logic                step;
    logic                carry;
    logic [4*DIGITS-1:0] count_next;
    logic [4*DIGITS-1:0] load_val;
    logic                nz_above;

    assign step = En && (pcnt == PTERM);

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    // Ripple carry/borrow: a digit moves only while every lower digit sits at its edge value.
    always_comb begin
        count_next = Count;
        load_val   = LoadVal;
        carry      = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (Up) begin
                if (carry)
                    count_next[4*i +: 4] = (Count[4*i +: 4] == DMAX) ? 4'd0 : Count[4*i +: 4] + 4'd1;
                carry = carry && (Count[4*i +: 4] == DMAX);
            end else begin
                if (carry)
                    count_next[4*i +: 4] = (Count[4*i +: 4] == 4'd0) ? DMAX : Count[4*i +: 4] - 4'd1;
                carry = carry && (Count[4*i +: 4] == 4'd0);
            end
            if ((DECIMAL != 0) && (LoadVal[4*i +: 4] > 4'd9))
                load_val[4*i +: 4] = 4'd9;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            pcnt  <= '0;
            Count <= '0;
            Tick  <= 1'b0;
            Wrap  <= 1'b0;
        end else if (Load) begin
            pcnt  <= '0;
            Count <= load_val;
            Tick  <= 1'b0;
            Wrap  <= 1'b0;
        end else begin
            Tick <= step;
            Wrap <= step && carry;
            if (En)
                pcnt <= step ? '0 : pcnt + PW'(1);
            if (step)
                Count <= count_next;
        end
    end

    // Scan from the top digit so a digit blanks only while everything above it is zero.
    always_comb begin
        HEX      = '0;
        nz_above = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nz_above = nz_above || (Count[4*i +: 4] != 4'd0);
            if ((BLANK_LZ != 0) && (i > 0) && !nz_above)
                HEX[7*i +: 7] = 7'h7F;
            else
                HEX[7*i +: 7] = seg7(Count[4*i +: 4]);
        end
    end

endmodule

// File: tb/tb_display_counter.sv
// Bench for display_counter: decimal, hex and blanking instances on one clock, scoreboard plus vector tables.
module tb_display_counter;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000, S9 = 7'b0010000, SA = 7'b0001000, SB = 7'b0000011;
    localparam logic [6:0] SC = 7'b1000110, SD = 7'b0100001, SE = 7'b0000110, SF = 7'b0001110;
    localparam logic [6:0] BL = 7'b1111111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, en, up, load;
    logic [7:0]  lv;
    logic [7:0]  cnt_a, cnt_h;
    logic [13:0] hex_a, hex_h;
    logic        tick_a, wrap_a, tick_h, wrap_h;
    logic        en_b, load_b;
    logic [15:0] lv_b, cnt_b;
    logic [27:0] hex_b;
    logic        tick_b, wrap_b;

    display_counter #(.DIGITS(2), .DECIMAL(1), .TICK_DIV(4), .BLANK_LZ(0)) dut_a (
        .Clock(clk), .Resetn(rst_n), .En(en), .Up(up), .Load(load), .LoadVal(lv),
        .Count(cnt_a), .HEX(hex_a), .Tick(tick_a), .Wrap(wrap_a));

    display_counter #(.DIGITS(2), .DECIMAL(0), .TICK_DIV(4), .BLANK_LZ(0)) dut_h (
        .Clock(clk), .Resetn(rst_n), .En(en), .Up(up), .Load(load), .LoadVal(lv),
        .Count(cnt_h), .HEX(hex_h), .Tick(tick_h), .Wrap(wrap_h));

    display_counter #(.DIGITS(4), .DECIMAL(1), .TICK_DIV(4), .BLANK_LZ(1)) dut_b (
        .Clock(clk), .Resetn(rst_n), .En(en_b), .Up(up), .Load(load_b), .LoadVal(lv_b),
        .Count(cnt_b), .HEX(hex_b), .Tick(tick_b), .Wrap(wrap_b));

    int checks   = 0;
    int failures = 0;
    int cyc_n    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc_n, act, exp);
        end
    endtask

    // Reference model works on plain integers, not digit chains.
    typedef struct packed {
        logic [7:0] ca;
        logic [7:0] ch;
        logic       ta;
        logic       th;
        logic       wa;
        logic       wh;
    } exp_t;

    exp_t sbq[$];
    int   m_pcnt, m_a, m_h;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    function automatic int clamp_dec(input logic [7:0] v);
        int hi, lo;
        hi = (v[7:4] > 4'd9) ? 9 : int'(v[7:4]);
        lo = (v[3:0] > 4'd9) ? 9 : int'(v[3:0]);
        return hi * 10 + lo;
    endfunction

    task automatic cyc();
        exp_t e, got;
        bit   st;
        e = '0;
        if (load) begin
            m_pcnt = 0;
            m_a    = clamp_dec(lv);
            m_h    = int'(lv);
        end else begin
            st   = en && (m_pcnt == 3);
            e.ta = st;
            e.th = st;
            if (en) m_pcnt = st ? 0 : m_pcnt + 1;
            if (st) begin
                if (up) begin
                    e.wa = (m_a == 99);
                    e.wh = (m_h == 255);
                    m_a  = (m_a + 1) % 100;
                    m_h  = (m_h + 1) % 256;
                end else begin
                    e.wa = (m_a == 0);
                    e.wh = (m_h == 0);
                    m_a  = (m_a + 99) % 100;
                    m_h  = (m_h + 255) % 256;
                end
            end
        end
        e.ca = to_bcd(m_a);
        e.ch = 8'(m_h);
        sbq.push_back(e);
        @(posedge clk);
        #1;
        cyc_n++;
        got = {cnt_a, cnt_h, tick_a, tick_h, wrap_a, wrap_h};
        e   = sbq.pop_front();
        chk("scoreboard", 64'(got), 64'(e));
    endtask

    task automatic model_reset();
        m_pcnt = 0;
        m_a    = 0;
        m_h    = 0;
        sbq.delete();
    endtask

    typedef struct {
        logic [7:0]  lv;
        logic [7:0]  ca;
        logic [13:0] ha;
        logic [7:0]  ch;
        logic [13:0] hh;
    } vec_t;

    typedef struct {
        logic [15:0] lv;
        logic [15:0] cnt;
        logic [27:0] hex;
    } vecb_t;

    vec_t  tv[7];
    vecb_t tb_v[5];

    initial begin
        int  first;
        bit  seen10;

        tv[0] = '{8'hFE, 8'h99, {S9, S9}, 8'hFE, {SF, SE}};
        tv[1] = '{8'hA5, 8'h95, {S9, S5}, 8'hA5, {SA, S5}};
        tv[2] = '{8'h37, 8'h37, {S3, S7}, 8'h37, {S3, S7}};
        tv[3] = '{8'h68, 8'h68, {S6, S8}, 8'h68, {S6, S8}};
        tv[4] = '{8'h4B, 8'h49, {S4, S9}, 8'h4B, {S4, SB}};
        tv[5] = '{8'hCD, 8'h99, {S9, S9}, 8'hCD, {SC, SD}};
        tv[6] = '{8'h12, 8'h12, {S1, S2}, 8'h12, {S1, S2}};

        tb_v[0] = '{16'h0300, 16'h0300, {BL, S3, S0, S0}};
        tb_v[1] = '{16'h1000, 16'h1000, {S1, S0, S0, S0}};
        tb_v[2] = '{16'h00A0, 16'h0090, {BL, BL, S9, S0}};
        tb_v[3] = '{16'h0000, 16'h0000, {BL, BL, BL, S0}};
        tb_v[4] = '{16'h0007, 16'h0007, {BL, BL, BL, S7}};

        rst_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; lv = '0;
        en_b = 1'b0; load_b = 1'b0; lv_b = '0;
        model_reset();
        #3;
        chk("rst_cnt_a", 64'(cnt_a), 64'h0);
        chk("rst_tick_wrap", 64'({tick_a, wrap_a, tick_h, wrap_h, tick_b, wrap_b}), 64'h0);
        chk("rst_hex_a", 64'(hex_a), 64'({S0, S0}));
        chk("rst_hex_b", 64'(hex_b), 64'({BL, BL, BL, S0}));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Count up from reset through the decade and the full wrap.
        en = 1'b1; up = 1'b1; seen10 = 1'b0;
        for (int i = 0; i < 396; i++) begin
            cyc();
            if (!seen10 && m_a == 10) begin
                seen10 = 1'b1;
                chk("hex_10", 64'(hex_a), 64'({S1, S0}));
            end
        end
        chk("cnt_99", 64'({cnt_a, hex_a}), 64'({8'h99, S9, S9}));
        repeat (4) cyc();
        chk("up_wrap", 64'({cnt_a, wrap_a}), 64'({8'h00, 1'b1}));
        cyc();
        chk("wrap_one_cycle", 64'(wrap_a), 64'h0);

        // Down from reset.
        rst_n = 1'b0; en = 1'b0; model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1; en = 1'b1; up = 1'b0;
        repeat (4) cyc();
        chk("dn_first", 64'({cnt_a, wrap_a}), 64'({8'h99, 1'b1}));
        repeat (4) cyc();
        chk("dn_second", 64'({cnt_a, wrap_a}), 64'({8'h98, 1'b0}));

        // Load vectors with En low: clamping and decode on both radices.
        en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            lv = tv[i].lv; load = 1'b1;
            cyc();
            load = 1'b0;
            chk($sformatf("ld_cnt_a[%0d]", i), 64'(cnt_a), 64'(tv[i].ca));
            chk($sformatf("ld_hex_a[%0d]", i), 64'(hex_a), 64'(tv[i].ha));
            chk($sformatf("ld_cnt_h[%0d]", i), 64'(cnt_h), 64'(tv[i].ch));
            chk($sformatf("ld_hex_h[%0d]", i), 64'(hex_h), 64'(tv[i].hh));
        end

        // Hex FE -> FF -> 00 with wrap.
        lv = 8'hFE; load = 1'b1;
        cyc();
        load = 1'b0; en = 1'b1; up = 1'b1;
        repeat (4) cyc();
        chk("h_ff", 64'({cnt_h, hex_h}), 64'({8'hFF, SF, SF}));
        repeat (4) cyc();
        chk("h_wrap", 64'({cnt_h, wrap_h}), 64'({8'h00, 1'b1}));

        // Load wins over a coincident step and restarts the prescaler.
        for (int i = 0; i < 8 && m_pcnt != 3; i++) cyc();
        lv = 8'h42; load = 1'b1;
        cyc();
        load = 1'b0;
        chk("ld_step", 64'({cnt_a, wrap_a, tick_a}), 64'({8'h42, 2'b00}));
        first = 0;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            if (tick_a && first == 0) first = i;
        end
        chk("ld_next_step", 64'(first), 64'd4);
        chk("ld_then_43", 64'(cnt_a), 64'h43);

        // Freeze mid-prescale, then resume the remaining cycles.
        for (int i = 0; i < 8 && m_pcnt != 1; i++) cyc();
        en = 1'b0;
        repeat (10) cyc();
        en = 1'b1; first = 0;
        for (int i = 1; i <= 6; i++) begin
            cyc();
            if (tick_a && first == 0) first = i;
        end
        chk("resume_edges", 64'(first), 64'd3);

        // Leading-zero blanking on the 4-digit instance.
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            lv_b = tb_v[i].lv; load_b = 1'b1;
            cyc();
            load_b = 1'b0;
            chk($sformatf("blank_cnt[%0d]", i), 64'(cnt_b), 64'(tb_v[i].cnt));
            chk($sformatf("blank_hex[%0d]", i), 64'(hex_b), 64'(tb_v[i].hex));
        end

        // Asynchronous reset in the middle of a Tick cycle.
        en = 1'b1; first = 0;
        for (int i = 1; i <= 8 && first == 0; i++) begin
            cyc();
            if (tick_a) first = i;
        end
        chk("pre_rst_tick", 64'(tick_a), 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_cnt", 64'({cnt_a, cnt_h, cnt_b}), 64'h0);
        chk("async_rst_pulses", 64'({tick_a, wrap_a, tick_h, wrap_h, tick_b, wrap_b}), 64'h0);
        chk("async_rst_hex_b", 64'(hex_b), 64'({BL, BL, BL, S0}));
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) cyc();
        chk("post_rst_first", 64'({cnt_a, tick_a}), 64'({8'h01, 1'b1}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/display_counter.md
Name: display_counter

Overview:
- Parametrised multi-digit up/down counter driving DE-series seven-segment displays; successor to the single-digit display block.
- Adds per-digit carry/borrow chain, selectable decimal (BCD) or hexadecimal radix, built-in prescaler, synchronous load, and leading-zero blanking.
- Instantiated in board tops fed by CLOCK_50, with KEY/SW on the control inputs and HEX0..HEX5 on the outputs.

Parameters:
- DIGITS, 6, number of 4-bit digits and HEX displays driven (1..8).
- DECIMAL, 1, 1 = BCD digits 0-9, 0 = hex digits 0-F.
- TICK_DIV, 50000000, Clock cycles per count step (>=2); 50000000 gives 1 Hz from CLOCK_50.
- BLANK_LZ, 0, 1 = blank leading zero digits (the least-significant digit is never blanked).

Ports:
- Clock  in  1  system clock (CLOCK_50 at top).
- Resetn  in  1  asynchronous active-low reset.
- En  in  1  count enable; also gates the prescaler.
- Up  in  1  1 = count up, 0 = count down.
- Load  in  1  synchronous load strobe.
- LoadVal  in  4*DIGITS  value loaded on Load, digit 0 in [3:0].
- Count  out  4*DIGITS  current count, digit i in [4i+3:4i].
- HEX  out  7*DIGITS  segments, display i in [7i+6:7i], bit0 = a .. bit6 = g, active-low.
- Tick  out  1  one-cycle pulse, prescaler terminal count.
- Wrap  out  1  one-cycle pulse after the counter rolls over in either direction.

Behaviour:
- Reset (Resetn=0, asynchronous): prescaler=0, Count=0, Tick=0, Wrap=0; HEX shows all "0" (BLANK_LZ=1: all digits blank except digit 0).
- Prescaler: pcnt is $clog2(TICK_DIV) bits wide. When En=1, pcnt increments each cycle and returns to 0 after TICK_DIV-1. When En=0, pcnt holds.
- Step condition: step = En & (pcnt==TICK_DIV-1).
- Tick: registered. Tick=1 for exactly the one cycle following each edge at which step was true.
- Count step: at the edge where step=1, Count +1 (Up=1) or -1 (Up=0).
  - Digit i changes only when all lower digits are at max (up) or 0 (down).
  - Digit max is 9 when DECIMAL=1, 15 when DECIMAL=0.
  - Up from all-max gives all-zero. Down from all-zero gives all-max.
  - Wrap=1 for exactly the one cycle following that edge.
- Load: synchronous. Has priority over step in the same cycle.
  - Count <= LoadVal. When DECIMAL=1, any digit >9 is stored as 9.
  - pcnt <= 0. No Tick, no Wrap.
  - Load acts regardless of En.
- Up is sampled only at step edges; toggling it between steps has no other effect.
- Decode is combinational from Count (zero latency). Active-low codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
  - blank=1111111.
- Leading-zero blanking (BLANK_LZ=1): digit i>0 is blank iff it and all higher digits are 0.
- Reset mid-count: immediate return to reset state; a pending step is discarded.

Test Plan:
1. DIGITS=2, DECIMAL=1, TICK_DIV=4, En=1, Up=1 from reset -> Count increments every 4 cycles. 09->10 gives HEX[6:0]=1000000 and HEX[13:7]=1111001. After 99 steps Count=99; next step gives Count=00 plus a one-cycle Wrap.
2. Same configuration, Up=0 from reset -> first step gives Count=99 and Wrap=1 for one cycle; next step gives 98.
3. DECIMAL=0, DIGITS=2: Load=1 with LoadVal=8'hFE, then step up -> FF, then 00 with Wrap. HEX for F is 0001110, E is 0000110. With DECIMAL=1, LoadVal=8'hA5 -> Count=95.
4. Load and step asserted in the same cycle with LoadVal=8'h42 -> Count=42, no Wrap, pcnt=0. The next step occurs exactly TICK_DIV cycles later.
5. En=0 for 10 cycles mid-prescale -> Count, pcnt and Tick are frozen. The step resumes after the remaining cycles once En returns to 1.
6. BLANK_LZ=1, DIGITS=4, Count=0007 -> HEX3..HEX1=1111111, HEX0=1111000. Assert Resetn=0 asynchronously mid-cycle -> Count=0 immediately, Tick=Wrap=0.
